forward_ctrl: RTL

// - Hazard and forwarding controller for the EX-stage operand forwarder (32-bit scalar and 128-bit vector paths).
// - Tracks destination-register tags through the EX, M and WB stages.
// - Drives per-operand forward enable and mode (0 = M, 1 = WB).
// - Detects load-use hazards and stalls ID with a one-cycle bubble; accepts a flush from branch resolution.

---
 rtl/forward_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/forward_ctrl.sv
// forward_ctrl -- hazard and forwarding controller for the EX-stage operand
// forwarder that serves both the 32-bit scalar and the 128-bit vector paths.
// It follows destination tags {vec, idx} through EX, M and WB. From those it
// produces per-operand forward enables and source modes (0 = M, 1 = WB). It
// also raises a one-cycle ID stall on a load-use hazard, and it accepts a
// flush from branch resolution.
// Optional feature: define HAZ_STATS_EN to build the saturating stall and
// forward statistics counters. Without it, stat_stalls and stat_fwds are 0.
module forward_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W:0]   id_src_a,
  input  logic [REG_W:0]   id_src_b,
  input  logic             id_rd_a,
  input  logic             id_rd_b,
  input  logic [REG_W:0]   id_dst,
  input  logic             id_wr,
  input  logic             id_load,
  input  logic             flush,
  output logic             stall,
  output logic             fwd_a_en,
  output logic             fwd_a_mode,
  output logic             fwd_b_en,
  output logic             fwd_b_mode,
  output logic [CNT_W-1:0] stat_stalls,
  output logic [CNT_W-1:0] stat_fwds
);

  localparam int TAG_W = REG_W + 1;
  // Scalar register 0 is hard-wired. Vector register 0 ({1, 0}) is not special.
  localparam logic [TAG_W-1:0] ZERO_TAG = '0;

  // A producer in a later stage supplies an operand that EX actually reads.
  // The zero tag never takes part in a match.
  function automatic logic f_match(input logic             prod_valid,
                                   input logic             prod_wr,
                                   input logic [TAG_W-1:0] prod_dst,
                                   input logic             cons_rd,
                                   input logic [TAG_W-1:0] cons_src);
    return prod_valid & prod_wr & cons_rd & (prod_dst == cons_src) &
           (cons_src != ZERO_TAG);
  endfunction

  // Saturating accumulate for the statistics counters.
  function automatic logic [CNT_W-1:0] f_sat_add(input logic [CNT_W-1:0] acc,
                                                 input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, acc} + {{(CNT_W-1){1'b0}}, inc};
    if (sum[CNT_W]) return {CNT_W{1'b1}};
    return sum[CNT_W-1:0];
  endfunction

  // Stage state. Only the valid bits are reset. The fields are qualified by
  // valid, so they simply follow their source.
  logic             r_ex_valid;
  logic [TAG_W-1:0] r_ex_src_a;
  logic [TAG_W-1:0] r_ex_src_b;
  logic             r_ex_rd_a;
  logic             r_ex_rd_b;
  logic [TAG_W-1:0] r_ex_dst;
  logic             r_ex_wr;
  logic             r_ex_load;

  logic             r_m_valid;
  logic [TAG_W-1:0] r_m_dst;
  logic             r_m_wr;

  logic             r_wb_valid;
  logic [TAG_W-1:0] r_wb_dst;
  logic             r_wb_wr;

  logic w_haz_a;
  logic w_haz_b;
  logic w_load_use;
  logic w_m_a;
  logic w_wb_a;
  logic w_m_b;
  logic w_wb_b;

  // ---- ID -> EX boundary: load-use hazard detection ----
  // A load in EX has no result until the end of M. A dependent instruction
  // in ID must therefore wait one cycle. After that it picks up the WB forward.
  always_comb begin
    w_haz_a    = id_rd_a & (id_src_a == r_ex_dst) & (id_src_a != ZERO_TAG);
    w_haz_b    = id_rd_b & (id_src_b == r_ex_dst) & (id_src_b != ZERO_TAG);
    w_load_use = r_ex_valid & r_ex_load & r_ex_wr & id_valid &
                 (w_haz_a | w_haz_b);
  end

  // Flush wins over a hazard. While reset is asserted, nothing is requested.
  always_comb begin
    stall = w_load_use & ~flush & ~rst;
  end

  // Stage valids: a stall or a flush turns the EX slot into a bubble.
  // M and WB always advance, so an instruction already in M still completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid <= 1'b0;
      r_m_valid  <= 1'b0;
      r_wb_valid <= 1'b0;
    end else begin
      r_ex_valid <= id_valid & ~stall & ~flush;
      r_m_valid  <= r_ex_valid;
      r_wb_valid <= r_m_valid;
    end
  end

  // Stage payload: the tags and flags move forward with their valid bit.
  always_ff @(posedge clk) begin
    r_ex_src_a <= id_src_a;
    r_ex_src_b <= id_src_b;
    r_ex_rd_a  <= id_rd_a;
    r_ex_rd_b  <= id_rd_b;
    r_ex_dst   <= id_dst;
    r_ex_wr    <= id_wr;
    r_ex_load  <= id_load;
    r_m_dst    <= r_ex_dst;
    r_m_wr     <= r_ex_wr;
    r_wb_dst   <= r_m_dst;
    r_wb_wr    <= r_m_wr;
  end

  // ---- EX operand selection from M / WB ----
  // An EX bubble still holds stale tags, so every match is qualified by
  // ex_valid.
  always_comb begin
    w_m_a  = r_ex_valid & f_match(r_m_valid,  r_m_wr,  r_m_dst,  r_ex_rd_a, r_ex_src_a);
    w_wb_a = r_ex_valid & f_match(r_wb_valid, r_wb_wr, r_wb_dst, r_ex_rd_a, r_ex_src_a);
    w_m_b  = r_ex_valid & f_match(r_m_valid,  r_m_wr,  r_m_dst,  r_ex_rd_b, r_ex_src_b);
    w_wb_b = r_ex_valid & f_match(r_wb_valid, r_wb_wr, r_wb_dst, r_ex_rd_b, r_ex_src_b);
  end

  // M is the newer result, so it takes priority over WB. The mode is 1 only
  // for a pure WB hit.
  always_comb begin
    fwd_a_en   = (w_m_a | w_wb_a) & ~rst;
    fwd_a_mode = ~w_m_a & w_wb_a & ~rst;
    fwd_b_en   = (w_m_b | w_wb_b) & ~rst;
    fwd_b_mode = ~w_m_b & w_wb_b & ~rst;
  end

`ifdef HAZ_STATS_EN
  logic [CNT_W-1:0] r_stat_stalls;
  logic [CNT_W-1:0] r_stat_fwds;
  logic [1:0]       w_fwd_inc;

  // Number of operands forwarded this cycle (0..2).
  always_comb begin
    w_fwd_inc = {1'b0, fwd_a_en} + {1'b0, fwd_b_en};
  end

  // Statistics: count stall cycles and forwarded operands. Both saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_stalls <= '0;
      r_stat_fwds   <= '0;
    end else begin
      r_stat_stalls <= f_sat_add(r_stat_stalls, {1'b0, stall});
      r_stat_fwds   <= f_sat_add(r_stat_fwds, w_fwd_inc);
    end
  end

  assign stat_stalls = r_stat_stalls;
  assign stat_fwds   = r_stat_fwds;
`else
  assign stat_stalls = '0;
  assign stat_fwds   = '0;
`endif

endmodule
